// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port arbiter.
// Used by noc_output_arbiter (optional perf counters: NOC_ARB_PERF_EN).
package noc_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   // Credit counter must hold every value 0..depth inclusive.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of eligible at or after
// rr_ptr, wrapping modulo N.
module rr_priority_picker
   import noc_arb_pkg::*;
#(
   parameter int N   = 5,
   parameter int IDX_W = index_width(N)
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             valid,
   output logic [IDX_W-1:0] winner
);

   int idx;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % N;
         if (eligible[idx]) begin
            valid  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output wormhole arbiter: round-robin head arbitration, grant held until
// the tail flit, sends gated by downstream credits. Perf counters: NOC_ARB_PERF_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ARB_IDLE   | no packet in flight; head flits arbitrate round-robin
// ARB_LOCKED | owner mid-packet; only owner may send, until its tail flit
module noc_output_arbiter
   import noc_arb_pkg::*;
#(
   parameter int NUM_INPUTS        = 5,
   parameter int FLIT_BUFFER_DEPTH = 1,
   parameter int CNT_WIDTH         = 32,
   localparam int CRED_W = credit_width(FLIT_BUFFER_DEPTH),
   localparam int IDX_W  = index_width(NUM_INPUTS)
) (
   input  logic                  clk_noc,
   input  logic                  rst_n,
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [NUM_INPUTS-1:0] req_tail,
   input  logic [NUM_INPUTS-1:0] turn_mask,
   input  logic                  credit_in,
   output logic [NUM_INPUTS-1:0] grant,
   output logic                  send_out,
   output logic                  locked,
   output logic [CRED_W-1:0]     credit_cnt,
   output logic                  credit_err,
   output logic [CNT_WIDTH-1:0]  flit_cnt,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   arb_state_t              state;
   logic [IDX_W-1:0]        owner;
   logic [IDX_W-1:0]        rr_ptr;
   logic [NUM_INPUTS-1:0]   eligible;
   logic [NUM_INPUTS-1:0]   grant_c;
   logic                    pick_valid;
   logic [IDX_W-1:0]        pick_winner;
   logic                    has_credit;
   logic                    cred_full;
   logic                    send;

   assign eligible   = req & ~turn_mask;
   assign has_credit = (credit_cnt != '0);
   assign cred_full  = (credit_cnt == CRED_W'(FLIT_BUFFER_DEPTH));

   rr_priority_picker #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_picker (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .valid    (pick_valid),
      .winner   (pick_winner)
   );

   always_comb begin
      grant_c = '0;
      if (state == ARB_IDLE) begin
         if (pick_valid && has_credit)
            grant_c[pick_winner] = 1'b1;
      end else begin
         if (req[owner] && has_credit)
            grant_c[owner] = 1'b1;
      end
   end

   // Registers already hold reset values during reset, but req may be live,
   // so the grant is forced off explicitly while rst_n is low.
   assign grant    = grant_c & {NUM_INPUTS{rst_n}};
   assign send     = |grant;
   assign send_out = send;
   assign locked   = (state == ARB_LOCKED);

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ARB_IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid && has_credit) begin
                  if (req_tail[pick_winner]) begin
                     rr_ptr <= IDX_W'(wrap_inc(int'(pick_winner), NUM_INPUTS));
                  end else begin
                     state <= ARB_LOCKED;
                     owner <= pick_winner;
                  end
               end
            end
            ARB_LOCKED: begin
               if (req[owner] && has_credit && req_tail[owner]) begin
                  state  <= ARB_IDLE;
                  rr_ptr <= IDX_W'(wrap_inc(int'(owner), NUM_INPUTS));
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         credit_cnt <= CRED_W'(FLIT_BUFFER_DEPTH);
         credit_err <= 1'b0;
      end else begin
         if (credit_in && cred_full)
            credit_err <= 1'b1;
         if (send && !credit_in)
            credit_cnt <= credit_cnt - CRED_W'(1);
         else if (!send && credit_in && !cred_full)
            credit_cnt <= credit_cnt + CRED_W'(1);
      end
   end

`ifdef NOC_ARB_PERF_EN
   logic stall_cond;

   assign stall_cond = ((state == ARB_IDLE) && (|eligible) ||
                        (state == ARB_LOCKED) && req[owner]) && !has_credit;

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         flit_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (send && !(&flit_cnt))
            flit_cnt <= flit_cnt + CNT_WIDTH'(1);
         if (stall_cond && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
   end
`else
   assign flit_cnt  = '0;
   assign stall_cnt = '0;
`endif

endmodule
